// File: rtl/scan_c2h_packer_pkg.sv
// Shared definitions for the scan-to-C2H packer: widths, output FSM states and a
// saturating counter helper.
package scan_c2h_packer_pkg;

  localparam int unsigned SCAN_SMP_W = 32;
  localparam int unsigned SCAN_DW    = 128;
  localparam int unsigned SCAN_LANES = SCAN_DW / SCAN_SMP_W;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } scan_state_e;

  // 16-bit add that sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/scan_c2h_packer_if.sv
// Frame-delimited word stream towards the sgdma_app C2H channel-0 reader.
//   data  : packed word
//   valid : word valid
//   start : first word of a frame (with valid)
//   stop  : last word of a frame (with valid)
// master drives the stream, slave consumes it.
interface scan_c2h_packer_if
  import scan_c2h_packer_pkg::*;
#(
  parameter int unsigned DW = SCAN_DW
) ();

  logic [DW-1:0] data;
  logic          valid;
  logic          start;
  logic          stop;

  modport master (output data, output valid, output start, output stop);
  modport slave  (input data, input valid, input start, input stop);

endinterface

// File: rtl/scan_sync_fifo.sv
// Synchronous show-ahead FIFO. dout always presents the head entry while not empty.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en, din : push (ignored while full)
//   rd_en      : pop (ignored while empty)
//   dout       : head entry
//   full, empty, level : occupancy status
module scan_sync_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 129
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  din,
  input  logic          rd_en,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned Depth = 1 << AW;

  logic [W-1:0]  mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign full  = (count_q == Depth[AW:0]);
  assign empty = (count_q == '0);
  assign level = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/scan_c2h_packer.sv
// Packs 32-bit scan samples into 128-bit words, buffers them and emits frame-delimited
// words to the C2H channel-0 reader. The scan source cannot stall: words that find the
// buffer full are dropped and counted.
//   usr_clk, usr_rst_n : clock, asynchronous active-low reset
//   c2h0r_run_i        : reader running; gates all output
//   frm_len_i          : frame length in words, latched at each frame start (0 means 1)
//   smp_data_i/valid_i/sof_i : sample stream
//   smp_ready_o        : at least two free buffer entries (advisory)
//   pcie               : output word stream (data/valid/start/stop)
//   drop_cnt_o         : saturating count of dropped samples
//   align_cnt_o        : saturating count of misaligned / truncated-frame events
module scan_c2h_packer
  import scan_c2h_packer_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned SMP_W   = SCAN_SMP_W,
  parameter int unsigned DW      = SCAN_DW
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst_n,
  input  logic                  c2h0r_run_i,
  input  logic [15:0]           frm_len_i,
  input  logic [SMP_W-1:0]      smp_data_i,
  input  logic                  smp_valid_i,
  input  logic                  smp_sof_i,
  output logic                  smp_ready_o,
  scan_c2h_packer_if.master     pcie,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           align_cnt_o
);

  localparam int unsigned Lanes = DW / SMP_W;
  localparam int unsigned LaneW = $clog2(Lanes);
  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);

  // ---------------- lane packer ----------------
  logic [LaneW-1:0]    lane_q, lane_d;
  logic [DW-SMP_W-1:0] word_q, word_d;      // lanes 0..Lanes-2; last lane goes straight out
  logic                tag_q, tag_d;
  logic                push_q, push_d;
  logic [DW:0]         push_word_q, push_word_d;
  logic                align_smp;

  always_comb begin
    lane_d      = lane_q;
    word_d      = word_q;
    tag_d       = tag_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    align_smp   = 1'b0;
    if (smp_valid_i) begin
      if (smp_sof_i) begin
        // A frame start always restarts packing in lane 0; any partial word is lost.
        word_d[SMP_W-1:0] = smp_data_i;
        lane_d            = LaneW'(1);
        tag_d             = 1'b1;
        align_smp         = (lane_q != '0);
      end else if (lane_q == LastLane) begin
        push_d      = 1'b1;
        push_word_d = {tag_q, smp_data_i, word_q};
        lane_d      = '0;
      end else begin
        word_d[lane_q*SMP_W +: SMP_W] = smp_data_i;
        if (lane_q == '0) tag_d = 1'b0;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      lane_q      <= '0;
      word_q      <= '0;
      tag_q       <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      lane_q      <= lane_d;
      word_q      <= word_d;
      tag_q       <= tag_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
    end
  end

  // ---------------- buffer ----------------
  logic [DW:0]      head;
  logic             fifo_full, fifo_empty, pop, push_ok;
  logic [FIFO_AW:0] fifo_level;

  scan_sync_fifo #(
    .AW (FIFO_AW),
    .W  (DW + 1)
  ) u_fifo (
    .clk   (usr_clk),
    .rst_n (usr_rst_n),
    .wr_en (push_q),
    .din   (push_word_q),
    .rd_en (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign pop     = c2h0r_run_i & ~fifo_empty;
  assign push_ok = push_q & ~fifo_full;   // a push into a full buffer is dropped even on a pop

  // ---------------- output FSM ----------------
  scan_state_e   state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, len_q, len_d, len_eff;
  logic          valid_q, valid_d, start_q, start_d, stop_q, stop_d;
  logic [DW-1:0] data_q, data_d;
  logic          align_fsm;

  assign len_eff = (frm_len_i == '0) ? 16'd1 : frm_len_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    data_d    = data_q;
    align_fsm = 1'b0;
    if (pop) begin
      case (state_q)
        StIdle: begin
          if (head[DW]) begin
            valid_d = 1'b1;
            start_d = 1'b1;
            data_d  = head[DW-1:0];
            len_d   = len_eff;
            cnt_d   = 16'd1;
            if (len_eff == 16'd1) stop_d = 1'b1;
            else                  state_d = StStream;
          end else begin
            align_fsm = 1'b1;   // orphan word outside any frame: discard
          end
        end
        StStream: begin
          valid_d = 1'b1;
          data_d  = head[DW-1:0];
          if (head[DW]) begin
            // New frame truncates the current one without a stop.
            start_d   = 1'b1;
            cnt_d     = 16'd1;
            len_d     = len_eff;
            align_fsm = 1'b1;
            if (len_eff == 16'd1) begin
              stop_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == len_q) begin
              stop_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------- counters and status ----------------
  logic [FIFO_AW+1:0] next_level;
  logic               ready_q, ready_d;
  logic [15:0]        drop_q, align_q;

  always_comb begin
    next_level = {1'b0, fifo_level} + {{(FIFO_AW + 1){1'b0}}, push_ok}
                 - {{(FIFO_AW + 1){1'b0}}, pop};
    ready_d    = (next_level <= (FIFO_AW + 2)'(Depth - 2));
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      drop_q  <= '0;
      align_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      drop_q  <= sat_add16(drop_q, (push_q & fifo_full) ? 16'd4 : 16'd0);
      align_q <= sat_add16(align_q, 16'(align_smp) + 16'(align_fsm));
    end
  end

  assign pcie.data   = data_q;
  assign pcie.valid  = valid_q;
  assign pcie.start  = start_q;
  assign pcie.stop   = stop_q;
  assign smp_ready_o = ready_q;
  assign drop_cnt_o  = drop_q;
  assign align_cnt_o = align_q;

endmodule
